mesh_loader: RTL

MESH_LOADER -- requirements
Module: mesh_loader

---
 rtl/subsurf_pkg.sv | 16 +
 rtl/mesh_loader.sv | 119 +++++++++++
 2 files changed

// File: rtl/subsurf_pkg.sv
// Shared definitions for the mesh loader: FSM state encoding and RAM geometry defaults.
package subsurf_pkg;

    localparam int DEPTH_DEF = 512;
    localparam int AW_DEF    = 9;

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        DRAIN    = 3'd1,
        KICK     = 3'd2,
        WAIT_BSY = 3'd3,
        RUN      = 3'd4,
        DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/mesh_loader.sv
// Streams a mesh into the input-mesh RAM, then starts subsurf and waits for it to finish.
// Optional running checksum of stored words: define MESH_LOADER_CHECKSUM_EN.
module mesh_loader
    import subsurf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    // A word transfers on a rising edge where s_valid && s_ready; the source holds
    // s_data/s_last stable while s_valid is high and s_ready is low.
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [31:0]   s_data,
    input  logic          s_last,
    output logic          en,
    output logic [3:0]    we,
    output logic [AW-1:0] a,
    output logic [31:0]   di,
    output logic          own,
    output logic          start,
    input  logic          busy,
    output logic          done,
    output logic [AW:0]   word_count,
    output logic          err_ovf,
    output logic [31:0]   checksum,
    output state_t        dbg_state
);

    state_t        state, state_nxt;
    logic          kick_wr;
    logic [AW-1:0] wr_ptr;
    logic          acc, acc_load, at_end;

    assign acc      = s_valid && s_ready;
    assign acc_load = acc && (state == LOAD);
    assign at_end   = (wr_ptr == AW'(DEPTH - 1));

    // kick_wr marks KICK's first cycle, while the final registered write is on the RAM port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= LOAD;
            kick_wr <= 1'b0;
        end else begin
            state   <= state_nxt;
            kick_wr <= (state != KICK) && (state_nxt == KICK);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD: begin
                if (acc) begin
                    if (s_last)      state_nxt = KICK;
                    else if (at_end) state_nxt = DRAIN;
                end
            end
            DRAIN:    if (acc && s_last) state_nxt = LOAD;
            KICK:     if (!kick_wr)      state_nxt = WAIT_BSY;
            WAIT_BSY: if (busy)          state_nxt = RUN;
            RUN:      if (!busy)         state_nxt = DONE;
            DONE:                        state_nxt = LOAD;
            default:                     state_nxt = LOAD;
        endcase
    end

    always_comb begin
        s_ready   = (state == LOAD) || (state == DRAIN);
        own       = (state == LOAD) || (state == DRAIN) || ((state == KICK) && kick_wr);
        start     = (state == KICK) && !kick_wr;
        done      = (state == DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            en         <= 1'b0;
            we         <= 4'h0;
            a          <= '0;
            di         <= '0;
            word_count <= '0;
            err_ovf    <= 1'b0;
        end else begin
            en <= acc_load;
            we <= acc_load ? 4'hF : 4'h0;
            if (acc_load) begin
                a      <= wr_ptr;
                di     <= s_data;
                wr_ptr <= wr_ptr + AW'(1);
                if (s_last)
                    word_count <= {1'b0, wr_ptr} + (AW+1)'(1);
                else if (at_end)
                    err_ovf <= 1'b1;
            end
            // An overflowed mesh is discarded; the next mesh starts at address 0.
            if ((state == DRAIN) && acc && s_last)
                wr_ptr <= '0;
            if (state == DONE)
                wr_ptr <= '0;
        end
    end

`ifdef MESH_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)
            checksum <= '0;
        else if ((state != LOAD) && (state_nxt == LOAD))
            checksum <= '0;
        else if (acc_load)
            checksum <= checksum + s_data;
    end
`else
    assign checksum = '0;
`endif

endmodule
